l15_req_port_arbiter: RTL and testbench

//  Shares the single L1.5 request channel between the I$ miss, D$ miss, D$ write-buffer,
//  D$ uncached read/write and AMO request ports of the HPDC-L1.5 adapter.

---
 rtl/sargantana_hpdc_pkg.sv | 22 ++
 rtl/l15_arb_prio_sel.sv | 26 ++
 rtl/l15_req_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_l15_req_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_hpdc_pkg.sv
// Shared definitions for the HPDC-L1.5 adapter request path.
//   l15_arb_state_t : request-channel arbiter FSM states
//   *_PORT          : fixed port indices of the requesters (0 = highest priority)
//   req_portid_t    : binary port identifier for the default six-port adapter
package sargantana_hpdc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } l15_arb_state_t;

    localparam int NUM_REQ_PORTS     = 6;
    localparam int ICACHE_PORT       = 0;
    localparam int DCACHE_MISS_PORT  = 1;
    localparam int DCACHE_WBUF_PORT  = 2;
    localparam int DCACHE_UC_RD_PORT = 3;
    localparam int DCACHE_UC_WR_PORT = 4;
    localparam int DCACHE_AMO_PORT   = 5;

    typedef logic [$clog2(NUM_REQ_PORTS)-1:0] req_portid_t;

endpackage

// File: rtl/l15_arb_prio_sel.sv
// Lowest-index priority picker: turns a request mask into the binary index of
// its lowest set bit.
//   req : request mask
//   any : at least one bit of req is set
//   idx : index of the lowest set bit (0 when req is empty)
module l15_arb_prio_sel #(
    parameter int N = 6
) (
    input  logic [N-1:0]         req,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    assign any = |req;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/l15_req_port_arbiter.sv
// Fixed-priority arbiter sharing the single L1.5 request channel between the
// adapter request ports (port 0 highest). The winner is frozen until the L1.5
// header ack, every grant is followed by one idle bubble, and issue is held
// off while MaxOutstanding transactions are waiting for a return.
// Optional feature macro: L15_ARB_STARVATION_GUARD_EN adds per-port wait
// counters; a port that has waited StarveTh cycles overrides fixed priority.
//   clk_i            : clock
//   reset_l          : asynchronous, active-low reset
//   req_valid_i      : per-port request pending, held until its req_ack_o
//   req_ack_o        : one-hot pulse, request accepted by L1.5
//   l15_val_o        : request valid toward L1.5
//   l15_portid_o     : port currently driving the L1.5 request mux
//   l15_header_ack_i : L1.5 accepted the current request
//   l15_rtrn_val_i   : L1.5 returned one response (frees one credit)
//   outstanding_o    : transactions in flight
//   err_o            : sticky, return received with nothing outstanding
module l15_req_port_arbiter
    import sargantana_hpdc_pkg::*;
#(
    parameter int NumPorts       = 6,
    parameter int MaxOutstanding = 4,
    parameter int StarveTh       = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_l,
    input  logic [NumPorts-1:0]               req_valid_i,
    output logic [NumPorts-1:0]               req_ack_o,
    output logic                              l15_val_o,
    output logic [$clog2(NumPorts)-1:0]       l15_portid_o,
    input  logic                              l15_header_ack_i,
    input  logic                              l15_rtrn_val_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                              err_o
);

    localparam int PW = $clog2(NumPorts);
    localparam int CW = $clog2(MaxOutstanding + 1);

    l15_arb_state_t state;
    logic           req_any;
    logic [PW-1:0]  req_idx;
    logic [PW-1:0]  sel_idx;
    logic           sel_any;
    logic           can_issue;
    logic           hdr_acc;

    l15_arb_prio_sel #(.N(NumPorts)) u_req_sel (
        .req (req_valid_i),
        .any (req_any),
        .idx (req_idx)
    );

`ifdef L15_ARB_STARVATION_GUARD_EN
    localparam int SW = $clog2(StarveTh + 1);

    logic [SW-1:0]       wait_cnt [NumPorts];
    logic [NumPorts-1:0] starved;
    logic                starved_any;
    logic [PW-1:0]       starved_idx;

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < NumPorts; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!req_valid_i[i] || req_ack_o[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != SW'(StarveTh))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    // Gate with req_valid_i so a port that just withdrew is never picked.
    always_comb begin
        for (int i = 0; i < NumPorts; i++)
            starved[i] = req_valid_i[i] && (wait_cnt[i] == SW'(StarveTh));
    end

    l15_arb_prio_sel #(.N(NumPorts)) u_starved_sel (
        .req (starved),
        .any (starved_any),
        .idx (starved_idx)
    );

    assign sel_idx = starved_any ? starved_idx : req_idx;
`else
    logic unused_starve_th;
    assign unused_starve_th = ^StarveTh;
    assign sel_idx          = req_idx;
`endif

    assign sel_any   = req_any;
    // Registered count: a return this cycle only unblocks issue next cycle.
    assign can_issue = outstanding_o < CW'(MaxOutstanding);
    assign hdr_acc   = (state == ISSUE) && l15_header_ack_i;

    always_comb begin
        req_ack_o = '0;
        if (hdr_acc) req_ack_o[l15_portid_o] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state        <= IDLE;
            l15_val_o    <= 1'b0;
            l15_portid_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any && can_issue) begin
                        l15_portid_o <= sel_idx;
                        l15_val_o    <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Grant is frozen; ack returns to IDLE for the mandatory bubble.
                    if (l15_header_ack_i) begin
                        l15_val_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    l15_val_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            outstanding_o <= '0;
            err_o         <= 1'b0;
        end else begin
            if (hdr_acc && !l15_rtrn_val_i) begin
                outstanding_o <= outstanding_o + 1'b1;
            end else if (!hdr_acc && l15_rtrn_val_i) begin
                if (outstanding_o == '0) err_o <= 1'b1;
                else                     outstanding_o <= outstanding_o - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l15_req_port_arbiter.sv
// Directed testbench for l15_req_port_arbiter.
module tb_l15_req_port_arbiter;

    localparam int NP = 6;
    localparam int MO = 4;
    localparam int ST = 16;

    logic          clk_i = 1'b0;
    logic          reset_l;
    logic [NP-1:0] req_valid_i;
    logic [NP-1:0] req_ack_o;
    logic          l15_val_o;
    logic [2:0]    l15_portid_o;
    logic          l15_header_ack_i;
    logic          l15_rtrn_val_i;
    logic [2:0]    outstanding_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    l15_req_port_arbiter #(
        .NumPorts(NP), .MaxOutstanding(MO), .StarveTh(ST)
    ) dut (
        .clk_i            (clk_i),
        .reset_l          (reset_l),
        .req_valid_i      (req_valid_i),
        .req_ack_o        (req_ack_o),
        .l15_val_o        (l15_val_o),
        .l15_portid_o     (l15_portid_o),
        .l15_header_ack_i (l15_header_ack_i),
        .l15_rtrn_val_i   (l15_rtrn_val_i),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic do_reset();
        reset_l          = 1'b0;
        req_valid_i      = '0;
        l15_header_ack_i = 1'b0;
        l15_rtrn_val_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_l = 1'b1;
        @(negedge clk_i);
    endtask

    // Waits (bounded) for a valid request, acks it for one cycle and
    // reports which port was acknowledged.
    task automatic grant_cycle(output bit got, output logic [NP-1:0] acked);
        acked = '0;
        for (int i = 0; i < 8 && !l15_val_o; i++) @(negedge clk_i);
        got = l15_val_o;
        if (got) begin
            l15_header_ack_i = 1'b1;
            #1 acked = req_ack_o;
            @(negedge clk_i);
            l15_header_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_l          = 1'b0;
        req_valid_i      = 6'b111111;
        l15_header_ack_i = 1'b1;
        l15_rtrn_val_i   = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (l15_val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", l15_val_o); end
        checks++;
        if (l15_portid_o !== 3'd0) begin errors++; $display("FAIL reset_portid: got %0d expected 0", l15_portid_o); end
        checks++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL reset_credit: got out=%0d err=%b expected 0/0", outstanding_o, err_o);
        end
        checks++;
        if (req_ack_o !== 6'b0) begin errors++; $display("FAIL reset_ack: got %b expected 000000", req_ack_o); end
        do_reset();
    endtask

    task automatic test_priority();
        do_reset();
        req_valid_i = 6'b000110;
        @(negedge clk_i);
        checks++;
        if (l15_val_o !== 1'b1 || l15_portid_o !== 3'd1) begin
            errors++; $display("FAIL prio_first: got val=%b port=%0d expected 1/1", l15_val_o, l15_portid_o);
        end
        l15_header_ack_i = 1'b1;
        #1;
        checks++;
        if (req_ack_o !== 6'b000010) begin errors++; $display("FAIL prio_ack1: got %b expected 000010", req_ack_o); end
        @(negedge clk_i);
        l15_header_ack_i = 1'b0;
        req_valid_i      = 6'b000100;
        checks++;
        if (l15_val_o !== 1'b0 || outstanding_o !== 3'd1) begin
            errors++; $display("FAIL prio_bubble: got val=%b out=%0d expected 0/1", l15_val_o, outstanding_o);
        end
        @(negedge clk_i);
        checks++;
        if (l15_val_o !== 1'b1 || l15_portid_o !== 3'd2) begin
            errors++; $display("FAIL prio_second: got val=%b port=%0d expected 1/2", l15_val_o, l15_portid_o);
        end
        // Higher-priority request during ISSUE must not steal the grant.
        req_valid_i = 6'b000101;
        @(negedge clk_i);
        checks++;
        if (l15_portid_o !== 3'd2) begin errors++; $display("FAIL prio_frozen: got %0d expected 2", l15_portid_o); end
        l15_header_ack_i = 1'b1;
        #1;
        checks++;
        if (req_ack_o !== 6'b000100) begin errors++; $display("FAIL prio_ack2: got %b expected 000100", req_ack_o); end
        @(negedge clk_i);
        l15_header_ack_i = 1'b0;
        req_valid_i      = '0;
        checks++;
        if (outstanding_o !== 3'd2) begin errors++; $display("FAIL prio_out: got %0d expected 2", outstanding_o); end
    endtask

    task automatic test_credit_limit();
        bit            got;
        logic [NP-1:0] acked;
        int            nack;
        bit            leaked;
        do_reset();
        req_valid_i = 6'b001000;
        nack = 0;
        for (int k = 0; k < 4; k++) begin
            grant_cycle(got, acked);
            if (got && acked == 6'b001000) nack++;
        end
        checks++;
        if (nack !== 4) begin errors++; $display("FAIL credit_acks: got %0d expected 4", nack); end
        checks++;
        if (outstanding_o !== 3'd4) begin errors++; $display("FAIL credit_full: got %0d expected 4", outstanding_o); end
        leaked = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (l15_val_o) leaked = 1'b1;
        end
        checks++;
        if (leaked !== 1'b0) begin errors++; $display("FAIL credit_block: got val=1 expected 0"); end
        l15_rtrn_val_i = 1'b1;
        @(negedge clk_i);
        l15_rtrn_val_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd3 || l15_val_o !== 1'b0) begin
            errors++; $display("FAIL credit_return: got out=%0d val=%b expected 3/0", outstanding_o, l15_val_o);
        end
        grant_cycle(got, acked);
        req_valid_i = '0;
        checks++;
        if (got !== 1'b1 || acked !== 6'b001000) begin
            errors++; $display("FAIL credit_fifth: got got=%b ack=%b expected 1/001000", got, acked);
        end
        checks++;
        if (outstanding_o !== 3'd4) begin errors++; $display("FAIL credit_refill: got %0d expected 4", outstanding_o); end
    endtask

    task automatic test_simultaneous();
        bit            got;
        logic [NP-1:0] acked;
        do_reset();
        req_valid_i = 6'b000001;
        grant_cycle(got, acked);
        grant_cycle(got, acked);
        checks++;
        if (outstanding_o !== 3'd2) begin errors++; $display("FAIL simul_pre: got %0d expected 2", outstanding_o); end
        for (int i = 0; i < 8 && !l15_val_o; i++) @(negedge clk_i);
        l15_header_ack_i = 1'b1;
        l15_rtrn_val_i   = 1'b1;
        @(negedge clk_i);
        l15_header_ack_i = 1'b0;
        l15_rtrn_val_i   = 1'b0;
        req_valid_i      = '0;
        checks++;
        if (outstanding_o !== 3'd2 || err_o !== 1'b0) begin
            errors++; $display("FAIL simul_keep: got out=%0d err=%b expected 2/0", outstanding_o, err_o);
        end
    endtask

    task automatic test_err();
        do_reset();
        l15_rtrn_val_i = 1'b1;
        @(negedge clk_i);
        l15_rtrn_val_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL err_set: got err=%b out=%0d expected 1/0", err_o, outstanding_o);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_o); end
        reset_l = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err_o); end
        do_reset();
    endtask

    task automatic test_starvation();
        int found;
        int p0_acks;
        do_reset();
        req_valid_i = 6'b100001;
        found   = -1;
        p0_acks = 0;
        for (int i = 0; i < 40; i++) begin
            l15_header_ack_i = l15_val_o;
            l15_rtrn_val_i   = l15_val_o;
            #1;
            if (req_ack_o[5] && found < 0) found = i;
            if (req_ack_o[0]) p0_acks++;
            @(negedge clk_i);
        end
        l15_header_ack_i = 1'b0;
        l15_rtrn_val_i   = 1'b0;
        req_valid_i      = '0;
`ifdef L15_ARB_STARVATION_GUARD_EN
        checks++;
        if (found < 0 || found > ST + 3) begin
            errors++; $display("FAIL starve_promote: got cycle %0d expected 0..%0d", found, ST + 3);
        end
`else
        checks++;
        if (found != -1) begin errors++; $display("FAIL starve_fixed: got port5 ack at %0d expected none", found); end
`endif
        checks++;
        if (p0_acks < 10) begin errors++; $display("FAIL starve_p0: got %0d acks expected >=10", p0_acks); end
        checks++;
        if (err_o !== 1'b0 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL starve_credit: got err=%b out=%0d expected 0/0", err_o, outstanding_o);
        end
    endtask

    task automatic test_reset_mid();
        bit            got;
        logic [NP-1:0] acked;
        do_reset();
        req_valid_i = 6'b010000;
        grant_cycle(got, acked);
        for (int i = 0; i < 8 && !l15_val_o; i++) @(negedge clk_i);
        checks++;
        if (l15_val_o !== 1'b1 || l15_portid_o !== 3'd4 || outstanding_o !== 3'd1) begin
            errors++; $display("FAIL mid_pre: got val=%b port=%0d out=%0d expected 1/4/1",
                               l15_val_o, l15_portid_o, outstanding_o);
        end
        #2 reset_l = 1'b0;
        l15_header_ack_i = 1'b1;
        #1;
        checks++;
        if (l15_val_o !== 1'b0 || outstanding_o !== 3'd0 || l15_portid_o !== 3'd0) begin
            errors++; $display("FAIL mid_clear: got val=%b out=%0d port=%0d expected 0/0/0",
                               l15_val_o, outstanding_o, l15_portid_o);
        end
        checks++;
        if (req_ack_o !== 6'b0) begin errors++; $display("FAIL mid_noack: got %b expected 000000", req_ack_o); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_credit_limit();
        test_simultaneous();
        test_err();
        test_starvation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
